// File: rtl/tx_sync_pkg.sv
// Shared types and helpers for the transmit-side synchroniser/arbiter.
// Holds the channel and engine state encodings and the channel-index width rule.
package tx_sync_pkg;

   typedef enum logic {
      CH_IDLE   = 1'b0,
      CH_ACTIVE = 1'b1
   } ch_state_t;

   typedef enum logic {
      ENG_IDLE = 1'b0,
      ENG_WAIT = 1'b1
   } eng_state_t;

   // A single channel still needs a 1-bit index port.
   function automatic int ch_width(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/tx_sync_arb_rr_arbiter.sv
// Round-robin arbiter: searches from last_ch+1 upward with wrap-around and
// grants the first requesting channel.
module rr_arbiter
   import tx_sync_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   last_ch,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx,
   output logic              any_req
);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      idx       = 0;
      found     = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = int'(last_ch) + k;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = CH_W'(idx);
         end
      end
   end

endmodule

// File: rtl/tx_sync_arb.sv
// Multi-channel one-shot handshake gating plus round-robin arbitration in front
// of a single UART transmitter load/ready interface.
module tx_sync_arb
   import tx_sync_pkg::*;
#(
   parameter  int NUM_CH        = 4,
   parameter  int DATA_W        = 8,
   parameter  int REARM_ON_DROP = 1,
   localparam int CH_W          = ch_width(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        Tx_valid,
   input  logic [NUM_CH*DATA_W-1:0] Tx_data,
   input  logic                     ready_reg,
   output logic [NUM_CH-1:0]        ready,
   output logic                     tx_load,
   output logic [DATA_W-1:0]        tx_data,
   output logic [CH_W-1:0]          tx_ch
);

   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   grant_idx;
   logic              any_req;
   logic              grant_en;
   logic [CH_W-1:0]   last_ch_reg;
   eng_state_t        eng_state_reg;
   eng_state_t        eng_state_next;

   // Per-channel one-shot: a channel is consumed by its grant and re-arms
   // either when its valid drops or on the following edge.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         ch_state_t state_reg;
         ch_state_t state_next;

         assign eligible[gi] = Tx_valid[gi] && (state_reg == CH_IDLE);

         always_comb begin
            state_next = state_reg;
            case (state_reg)
               CH_IDLE: begin
                  if (ready[gi]) begin
                     state_next = CH_ACTIVE;
                  end
               end
               CH_ACTIVE: begin
                  if ((REARM_ON_DROP == 0) || !Tx_valid[gi]) begin
                     state_next = CH_IDLE;
                  end
               end
               default: state_next = CH_IDLE;
            endcase
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg <= CH_IDLE;
            end else begin
               state_reg <= state_next;
            end
         end
      end
   endgenerate

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req       (eligible),
      .last_ch   (last_ch_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign grant_en = !reset && (eng_state_reg == ENG_IDLE) && ready_reg && any_req;
   assign ready    = grant_en ? grant : '0;
   assign tx_load  = |ready;

   // Engine holds off further grants until the transmitter has visibly gone busy.
   always_comb begin
      eng_state_next = eng_state_reg;
      case (eng_state_reg)
         ENG_IDLE: begin
            if (grant_en) begin
               eng_state_next = ENG_WAIT;
            end
         end
         ENG_WAIT: begin
            if (!ready_reg) begin
               eng_state_next = ENG_IDLE;
            end
         end
         default: eng_state_next = ENG_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         eng_state_reg <= ENG_IDLE;
         last_ch_reg   <= CH_W'(NUM_CH - 1);
      end else begin
         eng_state_reg <= eng_state_next;
         if (tx_load) begin
            last_ch_reg <= grant_idx;
         end
      end
   end

   always_comb begin
      tx_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ready[i]) begin
            tx_data = tx_data | Tx_data[i*DATA_W +: DATA_W];
         end
      end
   end

   generate
      if (NUM_CH == 1) begin : g_single
         assign tx_ch = '0;
      end else begin : g_multi
         assign tx_ch = tx_load ? grant_idx : '0;
      end
   endgenerate

endmodule

// File: tb/tb_tx_sync_arb.sv
// Scoreboard bench: three configurations share one stimulus stream; a reference
// model predicts each load, a negedge monitor compares what the DUTs present.
module tb_tx_sync_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rrdy = 1'b0;
   logic [3:0]  tv = 4'h0;
   logic [31:0] tdat = 32'h0;

   logic [3:0]  rdy0, rdy1;
   logic        rdy2;
   logic        ld0, ld1, ld2;
   logic [7:0]  dat0, dat1, dat2;
   logic [1:0]  ch0, ch1;
   logic        ch2;

   always #5 clk = ~clk;

   tx_sync_arb #(.NUM_CH(4), .DATA_W(8), .REARM_ON_DROP(1)) u_drop (
      .clk(clk), .reset(rst), .Tx_valid(tv), .Tx_data(tdat), .ready_reg(rrdy),
      .ready(rdy0), .tx_load(ld0), .tx_data(dat0), .tx_ch(ch0));

   tx_sync_arb #(.NUM_CH(4), .DATA_W(8), .REARM_ON_DROP(0)) u_stream (
      .clk(clk), .reset(rst), .Tx_valid(tv), .Tx_data(tdat), .ready_reg(rrdy),
      .ready(rdy1), .tx_load(ld1), .tx_data(dat1), .tx_ch(ch1));

   tx_sync_arb #(.NUM_CH(1), .DATA_W(8), .REARM_ON_DROP(1)) u_single (
      .clk(clk), .reset(rst), .Tx_valid(tv[0:0]), .Tx_data(tdat[7:0]), .ready_reg(rrdy),
      .ready(rdy2), .tx_load(ld2), .tx_data(dat2), .tx_ch(ch2));

   typedef struct {
      int         k;
      int         ch;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   cyc     = 0;

   // Reference model: consumed flags, lockout flag and last winner per instance.
   bit         cons [3][4];
   bit         waitf[3];
   int         last [3];
   int         pw   [3] = '{-1, -1, -1};
   bit         prst = 1'b1;
   bit         prdy = 1'b0;
   logic [3:0] pval = 4'h0;

   bit         log_en = 1'b0;
   int         log_ch[$];
   logic [7:0] log_d[$];

   function automatic int nch_of(input int k);
      return (k == 2) ? 1 : 4;
   endfunction

   function automatic bit rearm_on_drop(input int k);
      return (k != 1);
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, k, cyc, act, want);
      end
   endtask

   task automatic model_update(input int k);
      int n;
      n = nch_of(k);
      if (prst) begin
         for (int i = 0; i < 4; i++) cons[k][i] = 1'b0;
         waitf[k] = 1'b0;
         last[k]  = n - 1;
      end else begin
         for (int i = 0; i < n; i++) begin
            if (i == pw[k]) cons[k][i] = 1'b1;
            else if (cons[k][i] && (!rearm_on_drop(k) || !pval[i])) cons[k][i] = 1'b0;
         end
         if (pw[k] >= 0) begin
            waitf[k] = 1'b1;
            last[k]  = pw[k];
         end else if (!prdy) begin
            waitf[k] = 1'b0;
         end
      end
   endtask

   function automatic int model_pick(input int k);
      int n, c, w;
      n = nch_of(k);
      w = -1;
      if (!rst && !waitf[k] && rrdy) begin
         for (int o = 1; o <= n; o++) begin
            c = (last[k] + o) % n;
            if (w < 0 && tv[c] && !cons[k][c]) w = c;
         end
      end
      return w;
   endfunction

   // One clock of stimulus: retire the previous cycle in the model, drive, predict.
   task automatic step(input bit r, input bit rr, input logic [3:0] v, input logic [31:0] d);
      exp_t e;
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_update(k);
      #1;
      rst  = r;
      rrdy = rr;
      tv   = v;
      tdat = d;
      cyc++;
      for (int k = 0; k < 3; k++) begin
         pw[k] = model_pick(k);
         if (pw[k] >= 0) begin
            e.k    = k;
            e.ch   = pw[k];
            e.data = d[pw[k]*8 +: 8];
            e.cyc  = cyc;
            exp_q.push_back(e);
         end
      end
      prst = r;
      prdy = rr;
      pval = v;
   endtask

   logic       m_ld;
   int         m_ch;
   logic [7:0] m_d;
   logic [3:0] m_r;
   bit         m_want;
   exp_t       m_e;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin m_ld = ld0; m_ch = int'(ch0); m_d = dat0; m_r = rdy0; end
            1:       begin m_ld = ld1; m_ch = int'(ch1); m_d = dat1; m_r = rdy1; end
            default: begin m_ld = ld2; m_ch = int'(ch2); m_d = dat2; m_r = {3'b000, rdy2}; end
         endcase
         m_want = (exp_q.size() > 0) && (exp_q[0].k == k) && (exp_q[0].cyc == cyc);
         chk("tx_load", k, 32'(m_ld), 32'(m_want));
         if (m_want) begin
            m_e = exp_q.pop_front();
            chk("tx_ch", k, m_ch, m_e.ch);
            chk("tx_data", k, 32'(m_d), 32'(m_e.data));
            chk("ready_onehot", k, 32'(m_r), 32'(1) << m_e.ch);
            if (log_en && k == 1) begin
               log_ch.push_back(m_ch);
               log_d.push_back(m_d);
            end
         end else if (!m_ld) begin
            chk("idle_zero", k, {m_r, m_d, m_ch[1:0]}, 32'h0);
         end
      end
   end

   initial begin
      logic [31:0] da;
      logic [3:0]  v;
      bit          rr;
      int          rst_cnt;
      int          exp_seq[5];
      exp_seq = '{0, 1, 2, 3, 0};
      da = 32'hA3A2A1A0;

      // All channels valid from reset, transmitter alternating idle/busy.
      step(1, 0, 4'hF, da);
      step(1, 0, 4'hF, da);
      log_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 4'hF, da);
         step(0, 0, 4'hF, da);
      end
      log_en = 1'b0;
      chk("rr_seq_len", 1, log_ch.size(), 5);
      for (int i = 0; i < 5 && i < log_ch.size(); i++) begin
         chk("rr_seq_ch", 1, log_ch[i], exp_seq[i]);
         chk("rr_seq_data", 1, 32'(log_d[i]), 32'hA0 + exp_seq[i]);
      end

      // Grant ch2, hold stale ready, then reset mid-lockout with valid held.
      step(0, 0, 4'h0, da);
      step(0, 0, 4'h0, da);
      step(0, 1, 4'h4, da);
      for (int i = 0; i < 5; i++) step(0, 1, 4'h4, da);
      step(1, 1, 4'h4, da);
      step(1, 1, 4'h4, da);
      step(0, 1, 4'h4, da);
      step(0, 0, 4'h4, da);

      // last_ch=1 with ch1 and ch3 requesting: ch3 first, then ch1.
      step(1, 0, 4'h0, da);
      step(0, 1, 4'h2, da);
      step(0, 0, 4'h0, da);
      step(0, 1, 4'hA, da);
      step(0, 0, 4'hA, da);
      step(0, 1, 4'hA, da);
      step(0, 0, 4'h0, da);

      // Single-channel style: valid held 20 cycles, transmitter busy 3 cycles per load.
      step(1, 0, 4'h0, da);
      for (int i = 0; i < 20; i++) step(0, (i % 4) == 0, 4'h1, da);
      step(0, 0, 4'h0, da);
      for (int i = 0; i < 8; i++) step(0, (i % 4) == 0, 4'h1, da);

      // Randomised soak.
      v = 4'h0;
      rr = 1'b0;
      rst_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 4) == 0) v[c] = ~v[c];
         end
         if ($urandom_range(0, 2) == 0) rr = ~rr;
         if (rst_cnt == 0 && $urandom_range(0, 199) == 0) rst_cnt = $urandom_range(1, 3);
         step(rst_cnt != 0, rr, v, $urandom);
         if (rst_cnt != 0) rst_cnt--;
      end
      step(0, 0, 4'h0, 32'h0);
      @(posedge clk);
      #1;
      chk("queue_drained", 0, exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
